// File: rtl/afe_pkg.sv
// Shared definitions for the AFE data aggregator and its frame readout controller.
package afe_pkg;

  localparam int NUM_CH   = 128;
  localparam int DATA_W   = 16;
  localparam int IDX_W    = $clog2(NUM_CH);
  // Top bit of the readout index chooses the axis: 0 = y, 1 = x
  localparam int AXIS_BIT = IDX_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AGG_RST,
    ST_TRIGGER,
    ST_WAIT_FIN,
    ST_LOAD,
    ST_SEND,
    ST_DONE
  } frame_state_t;

endpackage

// File: rtl/frame_readout_controller.sv
// Sequences one acquisition frame: aggregator clear, AFE trigger, wait for finish,
// then streams y[0..NUM_CH-1] followed by x[0..NUM_CH-1] over a valid/ready link.
module frame_readout_controller
  import afe_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int AGG_RST_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              continuous,
  output logic              agg_reset,
  output logic              afe_trigger,
  input  logic              agg_finished,
  output logic [IDX_W-1:0]  read_index_yaxis,
  output logic [IDX_W-1:0]  read_index_xaxis,
  input  logic [DATA_W-1:0] out_data_yaxis,
  input  logic [DATA_W-1:0] out_data_xaxis,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              timeout,
  output logic [15:0]       frame_count
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RST_W = $clog2(AGG_RST_CYCLES + 1);
  localparam logic [IDX_W:0] LAST_IDX = (IDX_W + 1)'(2 * NUM_CH - 1);

  frame_state_t     state;
  frame_state_t     state_next;
  logic [IDX_W:0]   idx;
  logic [CNT_W-1:0] wait_cnt;
  logic [RST_W-1:0] rst_cnt;
  logic             handshake;
  logic             wait_expired;
  logic             rst_done;

  assign handshake        = m_valid & m_ready;
  assign wait_expired     = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign rst_done         = (rst_cnt == RST_W'(AGG_RST_CYCLES - 1));
  assign read_index_yaxis = idx[IDX_W-1:0];
  assign read_index_xaxis = idx[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    agg_reset   = 1'b0;
    afe_trigger = 1'b0;
    busy        = (state != ST_IDLE);
    case (state)
      ST_IDLE:     if (start) state_next = ST_AGG_RST;
      ST_AGG_RST: begin
        agg_reset = 1'b1;
        if (rst_done) state_next = ST_TRIGGER;
      end
      ST_TRIGGER: begin
        afe_trigger = 1'b1;
        state_next  = ST_WAIT_FIN;
      end
      ST_WAIT_FIN: begin
        if (agg_finished)      state_next = ST_LOAD;
        else if (wait_expired) state_next = ST_IDLE;
      end
      ST_LOAD:     state_next = ST_SEND;
      ST_SEND:     if (handshake) state_next = m_last ? ST_DONE : ST_LOAD;
      ST_DONE:     state_next = continuous ? ST_AGG_RST : ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  // Datapath: counters, axis index, output word register and status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      idx         <= '0;
      wait_cnt    <= '0;
      rst_cnt     <= '0;
      m_data      <= '0;
      m_valid     <= 1'b0;
      m_last      <= 1'b0;
      timeout     <= 1'b0;
      frame_count <= '0;
    end else begin
      rst_cnt <= (state == ST_AGG_RST) ? rst_cnt + 1'b1 : '0;
      case (state)
        ST_IDLE:    if (start) timeout <= 1'b0;
        ST_TRIGGER: begin
          wait_cnt <= '0;
          idx      <= '0;
        end
        ST_WAIT_FIN: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (!agg_finished && wait_expired) timeout <= 1'b1;
        end
        ST_LOAD: begin
          m_data  <= idx[AXIS_BIT] ? out_data_xaxis : out_data_yaxis;
          m_valid <= 1'b1;
          m_last  <= (idx == LAST_IDX);
        end
        ST_SEND: begin
          if (handshake) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            if (!m_last) idx <= idx + 1'b1;
          end
        end
        ST_DONE:    frame_count <= frame_count + 1'b1;
        default:    ;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_readout_controller.sv
// Scoreboard bench for frame_readout_controller with a behavioural aggregator model.
module tb_frame_readout_controller;
  import afe_pkg::*;

  localparam int TO          = 50;
  localparam int FRAME_WORDS = 2 * NUM_CH;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              continuous;
  logic              agg_reset;
  logic              afe_trigger;
  logic              agg_finished;
  logic [IDX_W-1:0]  read_index_yaxis;
  logic [IDX_W-1:0]  read_index_xaxis;
  logic [DATA_W-1:0] out_data_yaxis;
  logic [DATA_W-1:0] out_data_xaxis;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;
  logic              busy;
  logic              timeout;
  logic [15:0]       frame_count;

  frame_readout_controller #(.TIMEOUT_CYCLES(TO), .AGG_RST_CYCLES(2)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .continuous       (continuous),
    .agg_reset        (agg_reset),
    .afe_trigger      (afe_trigger),
    .agg_finished     (agg_finished),
    .read_index_yaxis (read_index_yaxis),
    .read_index_xaxis (read_index_xaxis),
    .out_data_yaxis   (out_data_yaxis),
    .out_data_xaxis   (out_data_xaxis),
    .m_data           (m_data),
    .m_valid          (m_valid),
    .m_ready          (m_ready),
    .m_last           (m_last),
    .busy             (busy),
    .timeout          (timeout),
    .frame_count      (frame_count)
  );

  always #5 clk = ~clk;

  // Aggregator contents: y[i] = i, x[i] = 0x100 + i
  assign out_data_yaxis = DATA_W'(read_index_yaxis);
  assign out_data_xaxis = 16'h0100 + DATA_W'(read_index_xaxis);

  int tests = 0;
  int fails = 0;
  logic [DATA_W:0] exp_q[$];
  int hs_count = 0;
  int last_count = 0;
  int agg_rst_cycles = 0;
  int trig_count = 0;
  int valid_seen = 0;
  bit finish_enable = 1'b1;
  int finish_delay = 10;
  int fin_cnt = -1;
  int ready_mode = 0;
  bit prev_stall = 1'b0;
  logic [DATA_W:0] prev_word = '0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic push_frame();
    logic [DATA_W:0] w;
    for (int i = 0; i < FRAME_WORDS; i++) begin
      if (i < NUM_CH) w[DATA_W-1:0] = DATA_W'(i);
      else            w[DATA_W-1:0] = 16'h0100 + DATA_W'(i - NUM_CH);
      w[DATA_W] = (i == FRAME_WORDS - 1);
      exp_q.push_back(w);
    end
  endtask

  task automatic applyStimulus(input bit expect_frame);
    if (expect_frame) push_frame();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  // Aggregator finished flag: rises finish_delay cycles after the trigger, cleared by agg_reset
  initial begin
    agg_finished = 1'b0;
    forever @(negedge clk) begin
      if (reset || agg_reset) begin
        agg_finished = 1'b0;
        fin_cnt = -1;
      end else begin
        if (afe_trigger && finish_enable) fin_cnt = finish_delay;
        else if (fin_cnt > 0) fin_cnt--;
        if (fin_cnt == 0) agg_finished = 1'b1;
      end
    end
  end

  // Ready generator: 0 = always ready, 1 = random 30 % duty, 2 = held low
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ($urandom_range(0, 99) < 30);
        default: m_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every handshake and checks stall stability
  initial begin
    logic [DATA_W:0] exp_word;
    forever @(negedge clk) begin
      if (!reset) begin
        if (agg_reset)   agg_rst_cycles++;
        if (afe_trigger) trig_count++;
        if (m_valid) begin
          valid_seen++;
          checkOutput("agg_reset_during_stream", 32'(agg_reset), 32'd0);
        end
        if (prev_stall)
          checkOutput("stall_hold", 32'({m_valid, m_last, m_data}), 32'({1'b1, prev_word}));
        prev_stall = m_valid && !m_ready;
        prev_word  = {m_last, m_data};
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL unexpected_word: got 0x%0h, expected no word", {m_last, m_data});
          end else begin
            exp_word = exp_q.pop_front();
            checkOutput("stream_word", 32'({m_last, m_data}), 32'(exp_word));
          end
          hs_count++;
          if (m_last) last_count++;
        end
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    int n;
    int base_fc, base_trig, base_rst, base_last, base_valid, base_hs;
    reset = 1'b1;
    start = 1'b0;
    continuous = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_agg_reset", 32'(agg_reset), 32'd0);
    checkOutput("rst_afe_trigger", 32'(afe_trigger), 32'd0);
    checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
    checkOutput("rst_m_last", 32'(m_last), 32'd0);
    checkOutput("rst_m_data", 32'(m_data), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_timeout", 32'(timeout), 32'd0);
    checkOutput("rst_frame_count", 32'(frame_count), 32'd0);
    checkOutput("rst_read_index", 32'({read_index_xaxis, read_index_yaxis}), 32'd0);
    reset = 1'b0;

    // Basic frame, always ready
    ready_mode = 0;
    base_rst = agg_rst_cycles; base_trig = trig_count; base_hs = hs_count;
    applyStimulus(1'b1);
    wait_idle("frame1", 5000);
    checkOutput("frame1_words", 32'(hs_count - base_hs), 32'(FRAME_WORDS));
    checkOutput("frame1_queue_empty", 32'(exp_q.size()), 32'd0);
    checkOutput("frame1_agg_reset_cycles", 32'(agg_rst_cycles - base_rst), 32'd2);
    checkOutput("frame1_triggers", 32'(trig_count - base_trig), 32'd1);
    checkOutput("frame1_count", 32'(frame_count), 32'd1);

    // Same frame under random backpressure
    ready_mode = 1;
    applyStimulus(1'b1);
    wait_idle("frame2", 20000);
    ready_mode = 0;
    checkOutput("frame2_queue_empty", 32'(exp_q.size()), 32'd0);
    checkOutput("frame2_count", 32'(frame_count), 32'd2);

    // Timeout: agg_finished never rises
    finish_enable = 1'b0;
    base_valid = valid_seen;
    applyStimulus(1'b0);
    n = 0;
    while (!afe_trigger && n < 20) begin @(negedge clk); n++; end
    checkOutput("timeout_trigger_seen", 32'(afe_trigger), 32'd1);
    // TIMEOUT_CYCLES WAIT_FIN cycles without timeout, flag visible on the next one
    n = 0;
    do begin @(negedge clk); n++; end while (!timeout && n < 200);
    checkOutput("timeout_latency", 32'(n), 32'(TO + 1));
    checkOutput("timeout_busy", 32'(busy), 32'd0);
    checkOutput("timeout_frame_count", 32'(frame_count), 32'd2);
    checkOutput("timeout_no_valid", 32'(valid_seen - base_valid), 32'd0);
    finish_enable = 1'b1;
    applyStimulus(1'b1);
    checkOutput("timeout_cleared", 32'(timeout), 32'd0);
    wait_idle("frame3", 5000);
    checkOutput("frame3_count", 32'(frame_count), 32'd3);

    // Continuous mode for three frames; finished already high on entry to WAIT_FIN
    finish_delay = 0;
    continuous = 1'b1;
    base_fc = frame_count; base_trig = trig_count; base_rst = agg_rst_cycles; base_last = last_count;
    push_frame();
    push_frame();
    applyStimulus(1'b1);
    n = 0;
    while (last_count < base_last + 2 && n < 5000) begin @(negedge clk); n++; end
    repeat (20) @(negedge clk);
    continuous = 1'b0;
    wait_idle("cont", 5000);
    checkOutput("cont_frames", 32'(frame_count - base_fc), 32'd3);
    checkOutput("cont_lasts", 32'(last_count - base_last), 32'd3);
    checkOutput("cont_triggers", 32'(trig_count - base_trig), 32'd3);
    checkOutput("cont_agg_reset_cycles", 32'(agg_rst_cycles - base_rst), 32'd6);
    checkOutput("cont_queue_empty", 32'(exp_q.size()), 32'd0);
    repeat (10) @(negedge clk);
    checkOutput("cont_stays_idle", 32'(busy), 32'd0);
    finish_delay = 10;

    // Reset while word 40 is being presented
    base_hs = hs_count;
    applyStimulus(1'b1);
    n = 0;
    while (!(hs_count >= base_hs + 40 && !m_valid) && n < 5000) begin @(negedge clk); n++; end
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    checkOutput("midreset_valid_before", 32'({m_valid, m_data}), 32'({1'b1, 16'h0028}));
    @(negedge clk);
    checkOutput("midreset_m_valid", 32'(m_valid), 32'd0);
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_frame_count", 32'(frame_count), 32'd0);
    exp_q.delete();
    reset = 1'b0;
    base_hs = hs_count;
    applyStimulus(1'b1);
    wait_idle("after_reset", 5000);
    checkOutput("after_reset_words", 32'(hs_count - base_hs), 32'(FRAME_WORDS));
    checkOutput("after_reset_count", 32'(frame_count), 32'd1);

    // Start pulses during WAIT_FIN, SEND and DONE are ignored
    base_trig = trig_count;
    applyStimulus(1'b1);
    n = 0;
    while (!afe_trigger && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    ready_mode = 2;
    n = 0;
    while (!m_valid && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (50) @(negedge clk);
    ready_mode = 0;
    n = 0;
    while (!(m_valid && m_last && m_ready) && n < 5000) begin @(negedge clk); n++; end
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("ignore_start_busy", 32'(busy), 32'd0);
    checkOutput("ignore_start_count", 32'(frame_count), 32'd2);
    checkOutput("ignore_start_triggers", 32'(trig_count - base_trig), 32'd1);
    checkOutput("ignore_start_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
